cpu_redundancy_arbiter: RTL and testbench

- N-way successor to the dual-CPU switch logic.
- Monitors per-CPU health lines and keeps a saturating error history per channel.
- Selects one active CPU by fault state and error history, with hysteresis and a post-switch holdoff.
- Honours a forced-switch command. Output sel_idx drives the serial-port mux and GPIO/switch outputs in the top level.

---
 rtl/cpu_arb_pkg.sv | 20 ++
 rtl/err_hist_counter.sv | 53 +++++
 rtl/cpu_redundancy_arbiter.sv | 160 ++++++++++++++++
 tb/tb_cpu_redundancy_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// rtl/cpu_arb_pkg.sv - shared state encoding, constants and helpers for the CPU redundancy arbiter
// Contents: arb_state_t (RUN/HOLD), HOLDOFF_CYC_DEF, clog2().
package cpu_arb_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  localparam int HOLDOFF_CYC_DEF = 1000;

  // Ceiling log2 with a floor of 1 so a 1-value range still gets a 1-bit field.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/err_hist_counter.sv
// rtl/err_hist_counter.sv - per-channel health synchroniser, fault edge detect and error history counter
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   io_ok      : raw health line (1=healthy), asynchronous to clk
//   shift      : rescale, halve the count this edge
//   clr        : clear the count this edge (wins over shift and increment)
//   err        : synchronised fault flag (1=faulty)
//   cnt        : saturating error count
module err_hist_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_ok,
  input  logic             shift,
  input  logic             clr,
  output logic             err,
  output logic [ERR_W-1:0] cnt
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value for edge detection.
  logic [2:0]       sync_q;
  logic             rise;
  logic [ERR_W-1:0] base;
  logic [ERR_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b111;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[1:0], io_ok};
      cnt    <= cnt_d;
    end
  end

  assign err  = ~sync_q[1];
  assign rise = ~sync_q[1] & sync_q[2];

  // Rescale first, then count a new fault on top of the halved value.
  always_comb begin
    base  = shift ? (cnt >> 1) : cnt;
    cnt_d = base;
    if (clr) begin
      cnt_d = '0;
    end else if (rise && (base != CNT_MAX)) begin
      cnt_d = base + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_redundancy_arbiter.sv
// rtl/cpu_redundancy_arbiter.sv - N-way active CPU selection from health lines and error history
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   io_ok        : per-CPU health lines (1=healthy), asynchronous
//   force_swi    : one-cycle forced switch request, com_sel is the target
//   sel_idx      : active CPU index, sel_onehot its one-hot decode
//   switch_pulse : one-cycle strobe when sel_idx changes
//   all_fail     : no channel healthy
//   holdoff      : post-switch holdoff timer running
//   err_cnt      : flattened error counters, channel 0 in the LSBs
module cpu_redundancy_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int N_CPU       = 2,
  parameter int IDX_W       = 1,
  parameter int ERR_W       = 8,
  parameter int HYST        = 2,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CPU-1:0]       io_ok,
  input  logic                   force_swi,
  input  logic [IDX_W-1:0]       com_sel,
  output logic [IDX_W-1:0]       sel_idx,
  output logic [N_CPU-1:0]       sel_onehot,
  output logic                   switch_pulse,
  output logic                   all_fail,
  output logic                   holdoff,
  output logic [N_CPU*ERR_W-1:0] err_cnt
);

  localparam int               TMR_W      = clog2(HOLDOFF_CYC);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(HOLDOFF_CYC - 1);
  localparam logic [ERR_W:0]   HYST_M     = (ERR_W + 1)'(HYST);

  logic [N_CPU-1:0] err;
  logic [N_CPU-1:0] healthy;
  logic [N_CPU-1:0] at_max;
  logic [ERR_W-1:0] cnt [N_CPU];
  logic             any_healthy;
  logic             shift;

  arb_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] sel_d;
  logic [N_CPU-1:0] onehot_d;
  logic             reload;

  logic [IDX_W-1:0] best;
  logic [ERR_W-1:0] best_cnt;
  logic             found;
  logic [ERR_W-1:0] act_cnt;
  logic             act_ok;
  logic             com_ok;
  logic             hist_ok;

  for (genvar g = 0; g < N_CPU; g++) begin : g_ch
    err_hist_counter #(.ERR_W(ERR_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .io_ok (io_ok[g]),
      .shift (shift),
      .clr   (force_swi),
      .err   (err[g]),
      .cnt   (cnt[g])
    );
    assign at_max[g]                 = &cnt[g];
    assign err_cnt[g*ERR_W +: ERR_W] = cnt[g];
  end

  assign healthy     = ~err;
  assign any_healthy = |healthy;
  // Any counter at the ceiling halves every counter, keeping their order.
  assign shift       = |at_max;
  assign holdoff     = (state_q == ST_HOLD);

  // Best healthy channel (lowest count, lowest index on ties) plus lookups
  // of the active and commanded channels without out-of-range indexing.
  always_comb begin
    best     = '0;
    best_cnt = '1;
    found    = 1'b0;
    act_cnt  = '0;
    act_ok   = 1'b0;
    com_ok   = 1'b0;
    for (int i = 0; i < N_CPU; i++) begin
      if (healthy[i] && (!found || (cnt[i] < best_cnt))) begin
        found    = 1'b1;
        best     = IDX_W'(i);
        best_cnt = cnt[i];
      end
      if (sel_idx == IDX_W'(i)) begin
        act_cnt = cnt[i];
        act_ok  = healthy[i];
      end
      if (com_sel == IDX_W'(i)) begin
        com_ok = healthy[i];
      end
    end
  end

  // One extra bit so best_cnt + HYST cannot wrap.
  assign hist_ok = ({1'b0, best_cnt} + HYST_M) <= {1'b0, act_cnt};

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_idx;
    reload  = 1'b0;
    if (force_swi) begin
      if (com_ok) begin
        sel_d = com_sel;
      end
      reload = 1'b1;
    end else if (!act_ok && any_healthy) begin
      sel_d  = best;
      reload = 1'b1;
    end else if ((state_q == ST_RUN) && act_ok && (best != sel_idx) && hist_ok) begin
      sel_d  = best;
      reload = 1'b1;
    end
    // With no healthy channel none of the above fires and sel_idx holds.

    if (reload) begin
      state_d = ST_HOLD;
      timer_d = TMR_RELOAD;
    end else if (state_q == ST_HOLD) begin
      if (timer_q == '0) begin
        state_d = ST_RUN;
      end else begin
        timer_d = timer_q - 1'b1;
      end
    end

    onehot_d = '0;
    for (int i = 0; i < N_CPU; i++) begin
      onehot_d[i] = (sel_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      timer_q      <= '0;
      sel_idx      <= '0;
      sel_onehot   <= N_CPU'(1);
      switch_pulse <= 1'b0;
      all_fail     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sel_idx      <= sel_d;
      sel_onehot   <= onehot_d;
      switch_pulse <= (sel_d != sel_idx);
      all_fail     <= ~any_healthy;
    end
  end

endmodule

// File: tb/tb_cpu_redundancy_arbiter.sv
// tb/tb_cpu_redundancy_arbiter.sv - directed self-checking bench for cpu_redundancy_arbiter
module tb_cpu_redundancy_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  io_ok;
  logic        force_swi;
  logic [1:0]  com_sel;
  logic [1:0]  sel_idx;
  logic [3:0]  sel_onehot;
  logic        switch_pulse;
  logic        all_fail;
  logic        holdoff;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_redundancy_arbiter #(
    .N_CPU(4), .IDX_W(2), .ERR_W(4), .HYST(2), .HOLDOFF_CYC(1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_ok        (io_ok),
    .force_swi    (force_swi),
    .com_sel      (com_sel),
    .sel_idx      (sel_idx),
    .sel_onehot   (sel_onehot),
    .switch_pulse (switch_pulse),
    .all_fail     (all_fail),
    .holdoff      (holdoff),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ch(input int ch, input int reps);
    for (int r = 0; r < reps; r++) begin
      io_ok[ch] = 1'b0;
      step(2);
      io_ok[ch] = 1'b1;
      step(3);
    end
  endtask

  task automatic do_force(input logic [1:0] target);
    com_sel   = target;
    force_swi = 1'b1;
    step(1);
    force_swi = 1'b0;
  endtask

  task automatic wait_holdoff_end();
    int n;
    n = 0;
    while (holdoff !== 1'b0 && n < 1100) begin
      step(1);
      n++;
    end
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL holdoff_timeout: holdoff=%b want 0 within 1100 cycles", holdoff); end
  endtask

  task automatic test_reset();
    rst = 1'b1; io_ok = 4'hF; force_swi = 1'b0; com_sel = 2'd0;
    step(3);
    rst = 1'b0;
    step(2);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (sel_onehot !== 4'b0001) begin n_bad++; $display("FAIL reset_onehot: got %b want 0001", sel_onehot); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL reset_holdoff: got %b want 0", holdoff); end
    n_cmp++; if (switch_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", switch_pulse); end
    n_cmp++; if (all_fail !== 1'b0) begin n_bad++; $display("FAIL reset_all_fail: got %b want 0", all_fail); end
  endtask

  task automatic test_fault_active();
    io_ok[0] = 1'b0;
    step(2);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL fault_early_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL fault_early_cnt: got %h want 0000", err_cnt); end
    step(1);
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL fault_sel: got %0d want 1", sel_idx); end
    n_cmp++; if (sel_onehot !== 4'b0010) begin n_bad++; $display("FAIL fault_onehot: got %b want 0010", sel_onehot); end
    n_cmp++; if (switch_pulse !== 1'b1) begin n_bad++; $display("FAIL fault_pulse: got %b want 1", switch_pulse); end
    n_cmp++; if (err_cnt !== 16'h0001) begin n_bad++; $display("FAIL fault_cnt: got %h want 0001", err_cnt); end
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL fault_holdoff: got %b want 1", holdoff); end
    io_ok[0] = 1'b1;
    step(1);
    n_cmp++; if (switch_pulse !== 1'b0) begin n_bad++; $display("FAIL fault_pulse_len: got %b want 0", switch_pulse); end
    step(998);
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL holdoff_last_cycle: got %b want 1", holdoff); end
    step(1);
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL holdoff_expire: got %b want 0", holdoff); end
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL fault_sel_stable: got %0d want 1", sel_idx); end
  endtask

  task automatic test_history();
    do_force(2'd0);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL hist_force_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL hist_force_clr: got %h want 0000", err_cnt); end
    pulse_ch(1, 3);
    pulse_ch(3, 3);
    io_ok[2] = 1'b0; io_ok[3] = 1'b0;
    step(4);
    io_ok[0] = 1'b0;
    step(4);
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL hist_preload_sel: got %0d want 1", sel_idx); end
    io_ok = 4'hF;
    step(4);
    pulse_ch(0, 4);
    n_cmp++; if (err_cnt !== 16'h4135) begin n_bad++; $display("FAIL hist_preload_cnt: got %h want 4135", err_cnt); end
    wait_holdoff_end();
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL hist_early: got %0d want 1", sel_idx); end
    step(1);
    n_cmp++; if (sel_idx !== 2'd2) begin n_bad++; $display("FAIL hist_switch: got %0d want 2", sel_idx); end
    n_cmp++; if (switch_pulse !== 1'b1) begin n_bad++; $display("FAIL hist_pulse: got %b want 1", switch_pulse); end
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL hist_holdoff: got %b want 1", holdoff); end
    pulse_ch(2, 1);
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL hist_refault_sel: got %0d want 1", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h4235) begin n_bad++; $display("FAIL hist_refault_cnt: got %h want 4235", err_cnt); end
    wait_holdoff_end();
    step(5);
    n_cmp++; if (sel_idx !== 2'd1) begin n_bad++; $display("FAIL hist_no_switch: got %0d want 1", sel_idx); end
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL hist_no_switch_hold: got %b want 0", holdoff); end
  endtask

  task automatic test_forced();
    do_force(2'd3);
    n_cmp++; if (sel_idx !== 2'd3) begin n_bad++; $display("FAIL force_sel: got %0d want 3", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL force_clr: got %h want 0000", err_cnt); end
    n_cmp++; if (switch_pulse !== 1'b1) begin n_bad++; $display("FAIL force_pulse: got %b want 1", switch_pulse); end
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL force_holdoff: got %b want 1", holdoff); end
    io_ok[3] = 1'b0;
    step(4);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL force_away_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h1000) begin n_bad++; $display("FAIL force_away_cnt: got %h want 1000", err_cnt); end
    do_force(2'd3);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL force_bad_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL force_bad_clr: got %h want 0000", err_cnt); end
    n_cmp++; if (switch_pulse !== 1'b0) begin n_bad++; $display("FAIL force_bad_pulse: got %b want 0", switch_pulse); end
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL force_bad_holdoff: got %b want 1", holdoff); end
    io_ok[3] = 1'b1;
    step(4);
  endtask

  task automatic test_saturation();
    do_force(2'd3);
    pulse_ch(1, 6);
    pulse_ch(0, 14);
    n_cmp++; if (err_cnt !== 16'h006E) begin n_bad++; $display("FAIL sat_preload: got %h want 006e", err_cnt); end
    io_ok[0] = 1'b0;
    step(2);
    n_cmp++; if (err_cnt !== 16'h006E) begin n_bad++; $display("FAIL sat_before: got %h want 006e", err_cnt); end
    step(1);
    n_cmp++; if (err_cnt !== 16'h006F) begin n_bad++; $display("FAIL sat_max: got %h want 006f", err_cnt); end
    step(1);
    n_cmp++; if (err_cnt !== 16'h0037) begin n_bad++; $display("FAIL sat_rescale: got %h want 0037", err_cnt); end
    io_ok[0] = 1'b1;
    step(4);
    pulse_ch(1, 3);
    pulse_ch(0, 7);
    n_cmp++; if (err_cnt !== 16'h006E) begin n_bad++; $display("FAIL sat_preload2: got %h want 006e", err_cnt); end
    io_ok[0] = 1'b0;
    step(1);
    io_ok[1] = 1'b0;
    step(2);
    n_cmp++; if (err_cnt !== 16'h006F) begin n_bad++; $display("FAIL sat_max2: got %h want 006f", err_cnt); end
    step(1);
    n_cmp++; if (err_cnt !== 16'h0047) begin n_bad++; $display("FAIL sat_rescale_inc: got %h want 0047", err_cnt); end
    io_ok = 4'hF;
    step(4);
  endtask

  task automatic test_all_fail();
    io_ok = 4'h0;
    step(2);
    n_cmp++; if (all_fail !== 1'b0) begin n_bad++; $display("FAIL allfail_early: got %b want 0", all_fail); end
    step(1);
    n_cmp++; if (all_fail !== 1'b1) begin n_bad++; $display("FAIL allfail_set: got %b want 1", all_fail); end
    n_cmp++; if (sel_idx !== 2'd3) begin n_bad++; $display("FAIL allfail_sel: got %0d want 3", sel_idx); end
    step(3);
    n_cmp++; if (all_fail !== 1'b1) begin n_bad++; $display("FAIL allfail_hold: got %b want 1", all_fail); end
    n_cmp++; if (sel_idx !== 2'd3) begin n_bad++; $display("FAIL allfail_sel_hold: got %0d want 3", sel_idx); end
    io_ok[2] = 1'b1;
    step(2);
    n_cmp++; if (all_fail !== 1'b1) begin n_bad++; $display("FAIL recover_early: got %b want 1", all_fail); end
    step(1);
    n_cmp++; if (all_fail !== 1'b0) begin n_bad++; $display("FAIL recover_clear: got %b want 0", all_fail); end
    n_cmp++; if (sel_idx !== 2'd2) begin n_bad++; $display("FAIL recover_sel: got %0d want 2", sel_idx); end
    n_cmp++; if (sel_onehot !== 4'b0100) begin n_bad++; $display("FAIL recover_onehot: got %b want 0100", sel_onehot); end
    n_cmp++; if (switch_pulse !== 1'b1) begin n_bad++; $display("FAIL recover_pulse: got %b want 1", switch_pulse); end
    n_cmp++; if (holdoff !== 1'b1) begin n_bad++; $display("FAIL recover_holdoff: got %b want 1", holdoff); end
  endtask

  task automatic test_reset_mid_hold();
    rst = 1'b1;
    #1;
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL midrst_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (sel_onehot !== 4'b0001) begin n_bad++; $display("FAIL midrst_onehot: got %b want 0001", sel_onehot); end
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL midrst_holdoff: got %b want 0", holdoff); end
    n_cmp++; if (err_cnt !== 16'h0000) begin n_bad++; $display("FAIL midrst_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (all_fail !== 1'b0) begin n_bad++; $display("FAIL midrst_all_fail: got %b want 0", all_fail); end
    io_ok = 4'hF;
    step(2);
    rst = 1'b0;
    step(4);
    n_cmp++; if (sel_idx !== 2'd0) begin n_bad++; $display("FAIL postrst_sel: got %0d want 0", sel_idx); end
    n_cmp++; if (holdoff !== 1'b0) begin n_bad++; $display("FAIL postrst_holdoff: got %b want 0", holdoff); end
    n_cmp++; if (all_fail !== 1'b0) begin n_bad++; $display("FAIL postrst_all_fail: got %b want 0", all_fail); end
  endtask

  initial begin
    test_reset();
    test_fault_active();
    test_history();
    test_forced();
    test_saturation();
    test_all_fail();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
